bus_term_fifo: RTL and testbench
================================

// Module: bus_term_fifo
// PURPOSE
// - Per-terminal transmit FIFO directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr).
// - Terminal side writes packets in; bus side sees pndng/D_pop and consumes words with pop.
// - One instance per terminal; the bus holds drvrs instances per bus (bits buses).
// - Packet format: [pckg_sz-1 -: 8] = destination ID (255 = broadcast); remainder = payload. Carried opaquely.
// PARAMETERS
// - pckg_sz      16  packet width in bits (>= 9)
// - profundidad  8   FIFO depth in words (>= 2, need not be a power of 2)
// PORTS
// - clk       in   1                            system clock; all logic on posedge
// - reset     in   1                            synchronous, active-high
// - wr_push   in   1                            terminal write strobe
// - wr_data   in   pckg_sz                      packet to write
// - full      out  1                            count == profundidad
// - pndng     out  1                            FIFO not empty (to bus pndng)
// - pop       in   1                            bus consumes head word
// - D_pop     out  pckg_sz                      head word (to bus D_pop)
// - count     out  $clog2(profundidad+1)        words stored
// - overflow  out  1                            1-cycle pulse: write hit a full FIFO
// - underflow out  1                            1-cycle pulse: pop while empty
// BEHAVIOUR
// - Reset: at the posedge with reset=1, rd_ptr = wr_ptr = count = 0.
//   Outputs after reset: pndng=0, full=0, D_pop=0, overflow=0, underflow=0.
//   Reset wins over wr_push/pop in the same cycle; memory contents are not cleared.
// - First-word-fall-through.
//   - D_pop = mem[rd_ptr] when pndng=1, else 0.
//   - A word written at edge N is visible on D_pop with pndng=1 after edge N.
//   - pop at edge M advances rd_ptr; the next word (or D_pop=0) is visible after edge M.
// - Pointers wrap from profundidad-1 to 0. count is derived from occupancy, not pointer difference.
// - Status flags pndng, full and count are registered and depend on state only.
// - Per-edge cases (E = empty, F = full):
//   - push only, !F: write, wr_ptr++, count++.
//   - pop only, !E: rd_ptr++, count--.
//   - pop, E: ignored; underflow=1 for one cycle.
//   - push+pop, !E and !F: both performed; count unchanged.
//   - push+pop, E: push performed, pop ignored, underflow=1, count=1.
//   - push+pop, F: both performed, count stays profundidad, no overflow.
//   - push only, F: see CONFIGURATION; overflow=1 for one cycle.
// - pop is only legal when pndng=1. The bus must sample D_pop in the same cycle it asserts pop.
// CONFIGURATION
// - FIFO_DROP_OLDEST_EN, when defined:
//   - push-only on full overwrites the head word.
//   - rd_ptr++ and wr_ptr++; count stays profundidad; the newest word is kept.
// - FIFO_DROP_OLDEST_EN, when undefined:
//   - push-only on full discards wr_data; pointers and count are unchanged.
// - overflow pulses in both builds.
// TESTING
// - Reset, then idle: pndng=0, D_pop=0, count=0, full=0 for 10 cycles.
// - Push 16'h0311, 16'h0422, 16'h0533; pop every cycle:
//   - D_pop shows 0311, 0422, 0533 in order, then 0; count goes 3 -> 0.
// - Push 8 words 16'h0100..16'h0107 (fills FIFO, full=1), then push 16'hFF99:
//   - Default build: overflow pulses; draining yields 0100..0107.
//   - FIFO_DROP_OLDEST_EN build: draining yields 0101..0107, FF99.
// - FIFO full: push 16'h0AAA and pop in the same cycle:
//   - D_pop=0100 consumed; count stays 8; 0AAA is drained last; no overflow.
// - FIFO empty: pop -> underflow=1 for one cycle, count=0.
//   - push+pop together -> count=1, D_pop = written word.
// - 5 words queued, reset asserted for 1 cycle with push=1:
//   - Next cycle count=0, pndng=0; the pushed word is discarded.
//   - Wrap check: 20 alternating push/pop cycles give correct data order.

Source files
------------

// File: rtl/bus_term_fifo_if.sv
// Terminal/bus port bundle for bus_term_fifo: write side from the terminal, pop side to the bus.
// The master modport belongs to whoever drives wr_push/wr_data/pop; the FIFO takes the slave modport.
interface bus_term_fifo_if #(
    parameter int pckg_sz     = 16,
    parameter int profundidad = 8
);
    localparam int CW = $clog2(profundidad + 1);

    // Handshake: a word moves out when pop=1 in a cycle where pndng=1, and the consumer
    // samples D_pop in that same cycle; wr_push accepts wr_data each cycle it is high unless full.
    logic               wr_push;
    logic [pckg_sz-1:0] wr_data;
    logic               full;
    logic               pndng;
    logic               pop;
    logic [pckg_sz-1:0] D_pop;
    logic [CW-1:0]      count;
    logic               overflow;
    logic               underflow;

    modport master (
        output wr_push, wr_data, pop,
        input  full, pndng, D_pop, count, overflow, underflow
    );

    modport slave (
        input  wr_push, wr_data, pop,
        output full, pndng, D_pop, count, overflow, underflow
    );
endinterface

// File: rtl/bus_term_fifo.sv
// Per-terminal first-word-fall-through transmit FIFO feeding the bus arbiter.
// Build option FIFO_DROP_OLDEST_EN: a push-only on full overwrites the head instead of dropping wr_data.
module bus_term_fifo #(
    parameter int pckg_sz     = 16,
    parameter int profundidad = 8
) (
    input  logic           clk,
    input  logic           reset,
    bus_term_fifo_if.slave bus
);
    localparam int CW = $clog2(profundidad + 1);
    localparam int PW = (profundidad > 1) ? $clog2(profundidad) : 1;

    logic [pckg_sz-1:0] mem [profundidad];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_next;
    logic               pndng_q;
    logic               full_q;
    logic               overflow_q;
    logic               underflow_q;
    logic               pop_ok;
    logic               push_ok;
    logic               adv_rd;

    assign pop_ok = bus.pop && pndng_q;

`ifdef FIFO_DROP_OLDEST_EN
    // On full, wr_ptr == rd_ptr, so writing and advancing both pointers replaces the oldest word.
    assign push_ok = bus.wr_push;
    assign adv_rd  = pop_ok || (bus.wr_push && full_q);
`else
    assign push_ok = bus.wr_push && (!full_q || pop_ok);
    assign adv_rd  = pop_ok;
`endif

    always_comb begin
        count_next = count_q;
        if (push_ok && !adv_rd) begin
            count_next = count_q + CW'(1);
        end else if (adv_rd && !push_ok) begin
            count_next = count_q - CW'(1);
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(profundidad - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            pndng_q     <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (adv_rd)  rd_ptr <= ptr_inc(rd_ptr);
            count_q     <= count_next;
            pndng_q     <= (count_next != '0);
            full_q      <= (count_next == CW'(profundidad));
            overflow_q  <= bus.wr_push && full_q && !pop_ok;
            underflow_q <= bus.pop && !pndng_q;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.D_pop     = pndng_q ? mem[rd_ptr] : '0;
    assign bus.pndng     = pndng_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_bus_term_fifo.sv
// Directed scoreboard bench for bus_term_fifo: drivers queue expected words, a negedge monitor checks pops.
module tb_bus_term_fifo;
    localparam int W = 16;
    localparam int D = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    bus_term_fifo_if #(.pckg_sz(W), .profundidad(D)) bif ();

    bus_term_fifo #(.pckg_sz(W), .profundidad(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input bit kept);
        bif.wr_push = 1'b1;
        bif.wr_data = d;
        if (kept) exp_q.push_back(d);
        tick();
        bif.wr_push = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bif.pop = 1'b1;
        repeat (n) tick();
        bif.pop = 1'b0;
    endtask

    // scoreboard monitor: the bus samples D_pop in the same cycle it pops
    always @(negedge clk) begin
        if (!reset && bif.pop && bif.pndng) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %0h expected no word", bif.D_pop);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bif.D_pop !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", bif.D_pop, e);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bif.wr_push = 1'b0;
        bif.wr_data = '0;
        bif.pop     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // idle after reset
        chk("ovf_reset", bif.overflow, 0);
        chk("udf_reset", bif.underflow, 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_pndng", bif.pndng, 0);
            chk("idle_dpop", bif.D_pop, 0);
            chk("idle_count", bif.count, 0);
            chk("idle_full", bif.full, 0);
            tick();
        end

        // three words then drain
        push(16'h0311, 1'b1);
        chk("fwft_first", bif.D_pop, 16'h0311);
        push(16'h0422, 1'b1);
        push(16'h0533, 1'b1);
        chk("count3", bif.count, 3);
        bif.pop = 1'b1;
        tick(); chk("count2", bif.count, 2);
        tick(); chk("count1", bif.count, 1);
        tick(); chk("count0", bif.count, 0);
        bif.pop = 1'b0;
        chk("drain_dpop", bif.D_pop, 0);
        chk("drain_pndng", bif.pndng, 0);

        // fill, then push on full
        for (int i = 0; i < D; i++) begin
            chk("fill_full_low", bif.full, 0);
            push(W'(16'h0100 + i), 1'b1);
        end
        chk("full_set", bif.full, 1);
        chk("full_count", bif.count, 8);
`ifdef FIFO_DROP_OLDEST_EN
        void'(exp_q.pop_front());
        push(16'hFF99, 1'b1);
`else
        push(16'hFF99, 1'b0);
`endif
        chk("ovf_pulse", bif.overflow, 1);
        chk("ovf_count", bif.count, 8);
        tick();
        chk("ovf_clear", bif.overflow, 0);

        // push + pop on full
        bif.pop = 1'b1;
        push(16'h0AAA, 1'b1);
        bif.pop = 1'b0;
        chk("pp_full_count", bif.count, 8);
        chk("pp_full_ovf", bif.overflow, 0);
        pop_n(D);
        chk("drain2_count", bif.count, 0);
        chk("drain2_pndng", bif.pndng, 0);

        // empty: pop alone, then push + pop together
        pop_n(1);
        chk("udf_pulse", bif.underflow, 1);
        chk("udf_count", bif.count, 0);
        tick();
        chk("udf_clear", bif.underflow, 0);
        bif.pop = 1'b1;
        push(16'h0BEE, 1'b1);
        bif.pop = 1'b0;
        chk("pp_empty_udf", bif.underflow, 1);
        chk("pp_empty_count", bif.count, 1);
        chk("pp_empty_dpop", bif.D_pop, 16'h0BEE);
        pop_n(1);
        chk("pp_empty_drain", bif.count, 0);

        // reset with words queued and a push in flight
        for (int i = 0; i < 5; i++) push(W'(16'h0C00 + i), 1'b0);
        chk("pre_reset_count", bif.count, 5);
        reset = 1'b1;
        push(16'h0DDD, 1'b0);
        reset = 1'b0;
        chk("rst_count", bif.count, 0);
        chk("rst_pndng", bif.pndng, 0);
        chk("rst_dpop", bif.D_pop, 0);
        push(16'h0E01, 1'b1);
        chk("post_rst_count", bif.count, 1);
        pop_n(1);

        // alternating push/pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) push(W'(16'h2000 + i), 1'b1);
            else pop_n(1);
        end
        chk("wrap_count", bif.count, 0);

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
